// File: rtl/reg_write_sequencer_pkg.sv
// rtl/reg_write_sequencer_pkg.sv - shared types and defaults for the register write sequencer
package reg_write_sequencer_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_DRIVE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  choice;
    } cmd_t;

endpackage

// File: rtl/reg_write_sequencer_cmd_fifo.sv
// rtl/reg_write_sequencer_cmd_fifo.sv - circular command buffer with push/pop/count/flush
module reg_write_sequencer_cmd_fifo #(
    parameter int W      = 17,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [W-1:0]      i_push_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [W-1:0]      o_head,
    output logic [ADDR_W:0]   o_count
);

    logic [W-1:0]      r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign w_push_ok = i_push && (r_count != (ADDR_W+1)'(DEPTH));
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            // Flush discards everything queued: read side jumps to write side.
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reg_write_sequencer.sv
// rtl/reg_write_sequencer.sv - replays buffered (data, choice) writes into a load/hold register and checks read-back
module reg_write_sequencer
    import reg_write_sequencer_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = 3,
    parameter int READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic              i_cmd_choice,
    input  logic              i_start,
    output logic [DATA_W-1:0] o_write_port_1,
    output logic              o_choice,
    input  logic [DATA_W-1:0] i_read_port_1,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W-1:0] o_err_index,
    output logic [DATA_W-1:0] o_err_expected,
    output logic [DATA_W-1:0] o_err_actual,
    output logic [ADDR_W:0]   o_pass_count
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_shadow;
    logic [ADDR_W-1:0]   r_idx;
    logic [1:0]          r_lat;
    logic [ADDR_W:0]     r_pass;
    logic [ADDR_W-1:0]   r_err_index;
    logic [DATA_W-1:0]   r_err_expected;
    logic [DATA_W-1:0]   r_err_actual;
    logic [DATA_W-1:0]   r_write;
    logic                r_choice;

    logic [DATA_W:0]     w_head;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_head_choice;
    logic [ADDR_W:0]     w_count;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_cmp_now;
    logic                w_flush;

    assign w_head_data   = w_head[DATA_W-1:0];
    assign w_head_choice = w_head[DATA_W];
    assign w_empty       = (w_count == '0);
    assign o_cmd_ready   = (r_state == S_IDLE) && (w_count != (ADDR_W+1)'(DEPTH));
    assign w_push        = i_cmd_valid && o_cmd_ready;
    assign w_pop         = (r_state == S_DRIVE);
    assign w_cmp_now     = (r_state == S_CHECK) && (r_lat == 2'(READ_LAT));
    assign w_flush       = w_cmp_now && (i_read_port_1 != r_shadow);

    reg_write_sequencer_cmd_fifo #(
        .W      (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_cmd_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data ({i_cmd_choice, i_cmd_data}),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // Driven outputs are loaded on entry to DRIVE so they are valid for that whole cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_shadow       <= '0;
            r_idx          <= '0;
            r_lat          <= '0;
            r_pass         <= '0;
            r_err_index    <= '0;
            r_err_expected <= '0;
            r_err_actual   <= '0;
            r_write        <= '0;
            r_choice       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_shadow <= i_read_port_1;
                    r_pass   <= '0;
                    r_idx    <= '0;
                    if (w_empty) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state  <= S_DRIVE;
                        r_write  <= w_head_data;
                        r_choice <= w_head_choice;
                    end
                end
                S_DRIVE: begin
                    if (w_head_choice) begin
                        r_shadow <= w_head_data;
                    end
                    r_lat    <= 2'd1;
                    r_choice <= 1'b0;
                    r_state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (!w_cmp_now) begin
                        r_lat <= r_lat + 2'd1;
                    end else if (!w_flush) begin
                        r_pass <= r_pass + (ADDR_W+1)'(1);
                        r_idx  <= r_idx + ADDR_W'(1);
                        if (w_empty) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state  <= S_DRIVE;
                            r_write  <= w_head_data;
                            r_choice <= w_head_choice;
                        end
                    end else begin
                        r_err_index    <= r_idx;
                        r_err_expected <= r_shadow;
                        r_err_actual   <= i_read_port_1;
                        r_state        <= S_ERROR;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_state        <= S_IDLE;
                        r_err_index    <= '0;
                        r_err_expected <= '0;
                        r_err_actual   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_write_port_1 = r_write;
    assign o_choice       = r_choice;
    assign o_busy         = (r_state == S_SAMPLE) || (r_state == S_DRIVE) || (r_state == S_CHECK);
    assign o_done         = (r_state == S_DONE);
    assign o_error        = (r_state == S_ERROR);
    assign o_err_index    = r_err_index;
    assign o_err_expected = r_err_expected;
    assign o_err_actual   = r_err_actual;
    assign o_pass_count   = r_pass;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// tb/tb_reg_write_sequencer.sv - directed and randomized bench for reg_write_sequencer
module tb_reg_write_sequencer;
    import reg_write_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_data = '0;
    logic        cmd_choice = 1'b0;
    logic        start = 1'b0;
    logic [15:0] write_port_1;
    logic        choice;
    logic [15:0] read_port_1;
    logic        busy, done, error;
    logic [2:0]  err_index;
    logic [15:0] err_expected, err_actual;
    logic [3:0]  pass_count;

    int n_checks = 0;
    int n_errors = 0;

    // Register under test: loads on choice, optionally refuses one data value.
    logic [15:0] reg_q;
    bit          fault_en = 1'b0;
    logic [15:0] fault_val = '0;
    cmd_t        mq[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) reg_q <= '0;
        else if (choice && !(fault_en && write_port_1 == fault_val)) reg_q <= write_port_1;
    end
    assign read_port_1 = reg_q;

    reg_write_sequencer dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_data     (cmd_data),
        .i_cmd_choice   (cmd_choice),
        .i_start        (start),
        .o_write_port_1 (write_port_1),
        .o_choice       (choice),
        .i_read_port_1  (read_port_1),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (error),
        .o_err_index    (err_index),
        .o_err_expected (err_expected),
        .o_err_actual   (err_actual),
        .o_pass_count   (pass_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic c);
        cmd_t e;
        chk("cmd_ready_before_push", {31'd0, cmd_ready}, {31'd0, mq.size() < 8});
        cmd_valid = 1'b1;
        cmd_data = d;
        cmd_choice = c;
        if (mq.size() < 8) begin
            e.data = d;
            e.choice = c;
            mq.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Starts a run and checks it against the expected outcome of replaying mq.
    task automatic run(input bit disturb);
        logic [15:0] sh, rg, eexp, eact;
        int pass, eidx, drives, cyc, k;
        bit err, ended;
        sh = reg_q; rg = reg_q; pass = 0; err = 0; eidx = 0; eexp = '0; eact = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (!err) begin
                if (mq[i].choice) begin
                    sh = mq[i].data;
                    if (!(fault_en && mq[i].data == fault_val)) rg = mq[i].data;
                end
                if (rg != sh) begin
                    err = 1; eidx = i; eexp = sh; eact = rg;
                end else begin
                    pass++;
                end
            end
        end
        drives = pass + (err ? 1 : 0);

        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        ended = 0;
        while (!ended && cyc < 200) begin
            start = 1'b0;
            cmd_valid = 1'b0;
            k = (cyc - 2) / 2;
            if (cyc >= 2 && cyc % 2 == 0 && k < drives) begin
                chk("drive_data", {16'd0, write_port_1}, {16'd0, mq[k].data});
                chk("drive_choice", {31'd0, choice}, {31'd0, mq[k].choice});
            end else begin
                chk("idle_choice", {31'd0, choice}, 32'd0);
            end
            if (done || error) begin
                ended = 1;
            end else begin
                chk("busy", {31'd0, busy}, 32'd1);
                chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
                if (disturb && cyc == 3) begin
                    start = 1'b1;
                    cmd_valid = 1'b1;
                    cmd_data = 16'h1234;
                    cmd_choice = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        cmd_valid = 1'b0;
        chk("run_ended", {31'd0, ended}, 32'd1);
        chk("run_cycles", cyc, 2 * drives + 2);
        chk("done", {31'd0, done}, {31'd0, !err});
        chk("error", {31'd0, error}, {31'd0, err});
        chk("pass_count", {28'd0, pass_count}, pass);
        chk("ready_end", {31'd0, cmd_ready}, 32'd0);
        if (err) begin
            chk("err_index", {29'd0, err_index}, eidx);
            chk("err_expected", {16'd0, err_expected}, {16'd0, eexp});
            chk("err_actual", {16'd0, err_actual}, {16'd0, eact});
        end
        mq.delete();
    endtask

    task automatic go_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_error", {31'd0, error}, 32'd0);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_err_expected", {16'd0, err_expected}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_choice", {31'd0, choice}, 32'd0);
        chk("rst_write", {16'd0, write_port_1}, 32'd0);
        chk("rst_pass", {28'd0, pass_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Five-command list, healthy register.
        push(16'd0, 1); push(16'd65, 1); push(16'd32, 0); push(16'd241, 0); push(16'd6202, 1);
        run(0);
        chk("t1_pass5", {28'd0, pass_count}, 32'd5);
        go_idle();

        // Same list, register refuses 6202.
        fault_en = 1'b1; fault_val = 16'd6202;
        push(16'd0, 1); push(16'd65, 1); push(16'd32, 0); push(16'd241, 0); push(16'd6202, 1);
        run(0);
        chk("t2_err_index", {29'd0, err_index}, 32'd4);
        chk("t2_err_exp", {16'd0, err_expected}, 32'd6202);
        chk("t2_err_act", {16'd0, err_actual}, 32'd65);
        chk("t2_pass4", {28'd0, pass_count}, 32'd4);
        go_idle();
        fault_en = 1'b0;

        // Nine pushes: only eight fit.
        for (int i = 0; i < 9; i++) push(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        run(0);
        chk("t3_pass8", {28'd0, pass_count}, 32'd8);
        go_idle();

        // Empty buffer.
        run(0);
        chk("t4_pass0", {28'd0, pass_count}, 32'd0);
        go_idle();

        // Reset during CHECK of command index 2.
        push(16'd11, 1); push(16'd22, 1); push(16'd33, 1); push(16'd44, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_in_check", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_choice", {31'd0, choice}, 32'd0);
        chk("t5_write", {16'd0, write_port_1}, 32'd0);
        chk("t5_pass", {28'd0, pass_count}, 32'd0);
        mq.delete();
        push(16'd93, 1); push(16'd256, 1);
        run(0);
        chk("t5_pass2", {28'd0, pass_count}, 32'd2);
        go_idle();

        // start and push while busy are ignored; buffer stays empty afterwards.
        push(16'd7, 1); push(16'd8, 0); push(16'd9, 1);
        run(1);
        go_idle();
        run(0);
        go_idle();

        // Randomized lists, sometimes with a refused data value.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) push(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            fault_en = 1'($urandom_range(0, 1));
            fault_val = mq[$urandom_range(0, n - 1)].data;
            run(0);
            go_idle();
            fault_en = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
